// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer in front of the big-endian data RAM
// Checks alignment/range, drives registered RAM strobes, returns load data or a fault.
module mem_access_unit #(
  parameter int MEM_BYTES   = 512,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic        req_se,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [8:0]  ram_A,
  output logic [31:0] ram_DI,
  output logic [1:0]  ram_Size,
  output logic        ram_RW,
  output logic        ram_E,
  output logic        ram_SE,
  input  logic [31:0] ram_DO,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        rsp_is_load,
  output logic [7:0]  fault_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        accept;
  logic        fault;

  assign accept = req_valid & req_ready;

  always_comb begin
    nbytes = 3'd1;
    case (req_size)
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd1;
    endcase
  end

  // One bit wider than the address so a wrap past 2^32 still counts as out of range.
  assign end_addr = {1'b0, req_addr} + {30'd0, nbytes};
  assign fault    = (req_size == 2'b11)
                  | ((req_size == 2'b01) & req_addr[0])
                  | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                  | (end_addr > 33'(MEM_BYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fault ? RESP : ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered so both read 0 throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'd0;
      rsp_fault   <= 1'b0;
      rsp_is_load <= 1'b0;
      fault_count <= 8'd0;
      ram_A       <= 9'd0;
      ram_DI      <= 32'd0;
      ram_Size    <= 2'd0;
      ram_RW      <= 1'b0;
      ram_E       <= 1'b0;
      ram_SE      <= 1'b0;
      wait_cnt    <= 4'd0;
    end else begin
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
      if (state == IDLE && accept) begin
        rsp_is_load <= ~req_rw;
        if (fault) begin
          rsp_fault <= 1'b1;
          rsp_rdata <= 32'd0;
          if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
        end else begin
          rsp_fault <= 1'b0;
          ram_A     <= req_addr[8:0];
          ram_DI    <= req_wdata;
          ram_Size  <= req_size;
          ram_SE    <= req_se;
          ram_RW    <= req_rw;
          ram_E     <= 1'b1;
          wait_cnt  <= 4'(WAIT_CYCLES - 1);
        end
      end
      // Address/data/size stay put after exit so the RAM never sees them move under E.
      if (state == ACCESS) begin
        if (wait_cnt == 4'd0) begin
          rsp_rdata <= ram_RW ? 32'd0 : ram_DO;
          ram_E     <= 1'b0;
          ram_RW    <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer directly upstream of the 512-byte big-endian data RAM.
- Accepts one memory request at a time from the pipeline MEM stage over a valid/ready handshake.
- Checks alignment and range, then drives the RAM's asynchronous A/DI/Size/RW/E/SE inputs from registers for a fixed number of cycles.
- Captures load data (ram_DO) and returns a response with a fault flag over a second valid/ready handshake.

Parameters:
- MEM_BYTES, 512, RAM size in bytes; any access whose last byte is at or above this address faults.
- WAIT_CYCLES, 1, cycles the RAM inputs are held with ram_E=1 before load data is captured; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_rw  in  1  0=load, 1=store
- req_size  in  2  00=byte, 01=halfword, 10=word, 11=illegal
- req_se  in  1  sign-extend for loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- ram_A  out  9  RAM byte address
- ram_DI  out  32  RAM store data
- ram_Size  out  2  RAM access size
- ram_RW  out  1  RAM direction, 1=write
- ram_E  out  1  RAM enable
- ram_SE  out  1  RAM sign-extend
- ram_DO  in  32  RAM load data (combinational from RAM)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  load data; 0 for stores and faults
- rsp_fault  out  1  request rejected, no RAM access made
- rsp_is_load  out  1  echo of ~req_rw for the response
- fault_count  out  8  saturating count of faulted requests

Behaviour:
- Reset (rst_n=0, async):
  - State goes to IDLE; ram_E and ram_RW go 0 immediately.
  - All other outputs are 0, including req_ready, rsp_valid and fault_count.
  - An in-flight request is dropped with no response.
  - req_ready rises on the first clock edge after rst_n deasserts.
- All ram_* outputs are driven from flops, with no combinational path from req_* to ram_*.
- FSM states:
  - IDLE:
    - req_ready=1, ram_E=0, ram_RW=0.
    - On req_valid&req_ready, latch rw/size/se/addr/wdata and evaluate the fault.
  - Fault evaluation:
    - Any of the following is a fault: size==11; halfword with addr[0]=1; word with addr[1:0]!=0; addr + bytes(size) > MEM_BYTES, where bytes(size) is 1, 2 or 4 and the check is on the full 32-bit address.
    - On fault: go to RESP with rsp_fault=1 and rsp_rdata=0; ram_E never rises; fault_count increments, saturating at 255.
    - On no fault: go to ACCESS.
  - ACCESS:
    - On entry edge, load ram_A=addr[8:0], ram_DI=wdata unmodified, ram_Size=size, ram_SE=se and ram_RW=rw; ram_E=1.
    - Wait counter loads WAIT_CYCLES-1 and decrements each cycle.
    - On the edge where the counter is 0: loads capture ram_DO into rsp_rdata; stores set rsp_rdata=0. ram_E and ram_RW go 0, and the state goes to RESP.
    - ram_E is high for exactly WAIT_CYCLES cycles.
    - ram_A/DI/Size/SE hold their values after exit and change only on the next ACCESS entry, so the RAM never sees an address change while E=1.
  - RESP:
    - rsp_valid=1; rsp_rdata, rsp_fault and rsp_is_load are held stable until rsp_ready.
    - On rsp_valid&rsp_ready, go to IDLE and drop rsp_valid.
    - req_ready=0 while in RESP.
- Latency:
  - Non-faulting request: accept edge to rsp_valid is WAIT_CYCLES+1 cycles.
  - Faulted request: 1 cycle.
- Throughput: at most one request per WAIT_CYCLES+2 cycles.
- Data width rules:
  - Byte and halfword sign/zero extension is done by the RAM; the unit passes ram_DO through unchanged.
  - req_se is ignored by the RAM for words but still forwarded.
- Boundaries:
  - Word at address 508 is legal; word at 512 faults; byte at 511 is legal.
  - req_valid held while busy is not accepted and must be held by the source.
  - rsp_ready held high in IDLE has no effect.
  - Reset asserted during ACCESS with rw=1: E falls asynchronously; the RAM may already hold the stored bytes, and no response is issued.

Test Plan:
- Store word 0xDEADBEEF at 0x40, then load word at 0x40 (WAIT_CYCLES=1) -> ram_E high 1 cycle per access; load response rsp_rdata=0xDEADBEEF, rsp_fault=0, rsp_valid 2 cycles after accept.
- Store byte 0x80 at 0x10; load byte with se=1 -> rsp_rdata=0xFFFFFF80; same load with se=0 -> 0x00000080.
- Halfword load at 0x21, word store at 0x42, size=11 at 0x0, word at 0x200 -> each returns rsp_fault=1 with ram_E never asserted; fault_count=4.
- Back-pressure: hold rsp_ready=0 for 5 cycles after a load -> rsp_valid and rsp_rdata stable for all 5 cycles, req_ready=0 throughout, IDLE reached the cycle after rsp_ready=1.
- WAIT_CYCLES=3: load word at 0x1FC -> ram_E high exactly 3 cycles with ram_A=0x1FC stable; response 4 cycles after accept.
- Pull rst_n low during ACCESS of a store -> ram_E=0 in the same cycle, no rsp_valid; after release, req_ready=1 and fault_count=0.
